// File: rtl/anita3_trig_pkg.sv
// Shared definitions for the ANITA-3 trigger gate: state encoding, source bit
// indices and default widths.
`timescale 1ns/1ps
package anita3_trig_pkg;

   localparam int NUM_SRC  = 4;
   localparam int SRC_RF   = 0;
   localparam int SRC_PPS  = 1;
   localparam int SRC_EXT  = 2;
   localparam int SRC_SOFT = 3;

   localparam int EVCNT_WIDTH_DEF = 32;
   localparam int DROP_WIDTH_DEF  = 16;
   localparam int HO_TIMEOUT_DEF  = 3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FIRE     = 2'd1,
      ST_WAIT_HO  = 2'd2,
      ST_WAIT_CLR = 2'd3
   } trig_state_e;

endpackage

// File: rtl/anita3_trig_edge.sv
// Rising-edge detector for one trigger source, qualified by its mask bit.
// The previous-level register tracks the input even while the source is masked.
`timescale 1ns/1ps
module anita3_trig_edge (
   input  logic clk250_i,
   input  logic rst_n_i,
   input  logic level,
   input  logic enable,
   output logic rise
);

   logic prev_q;

   always_ff @(posedge clk250_i or negedge rst_n_i) begin
      if (!rst_n_i) prev_q <= 1'b0;
      else          prev_q <= level;
   end

   assign rise = level & ~prev_q & enable;

endmodule

// File: rtl/anita3_trigger_gate.sv
// Merges RF/PPS/ext/soft sources into one trigger pulse for the holdoff block.
// Optional RF prescaler enabled by defining ANITA3_TRIG_PRESCALE_EN.
//
// state    | meaning
// IDLE     | waiting for an RF event or pending source while not busy/held off
// FIRE     | trig_o high for this single cycle
// WAIT_HO  | waiting (bounded) for the holdoff block to assert holdoff_i
// WAIT_CLR | waiting for holdoff_i to release
`timescale 1ns/1ps
module anita3_trigger_gate
   import anita3_trig_pkg::*;
#(
   parameter int EVCNT_WIDTH = EVCNT_WIDTH_DEF,
   parameter int DROP_WIDTH  = DROP_WIDTH_DEF,
   parameter int HO_TIMEOUT  = HO_TIMEOUT_DEF
) (
   input  logic                   clk250_i,
   input  logic                   rst_n_i,
   input  logic                   rf_trig_i,
   input  logic                   pps_trig_i,
   input  logic                   ext_trig_i,
   input  logic                   soft_trig_i,
`ifdef ANITA3_TRIG_PRESCALE_EN
   input  logic [7:0]             rf_prescale_i,
`endif
   input  logic [NUM_SRC-1:0]     trig_mask_i,
   input  logic                   busy_i,
   input  logic                   holdoff_i,
   output logic                   trig_o,
   output logic [NUM_SRC-1:0]     trig_type_o,
   output logic [EVCNT_WIDTH-1:0] event_count_o,
   output logic [DROP_WIDTH-1:0]  rf_dropped_o,
   output logic                   ho_error_o
);

   localparam int HO_W = (HO_TIMEOUT < 2) ? 1 : $clog2(HO_TIMEOUT);
   localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HO_TIMEOUT - 1);
   localparam logic [NUM_SRC-1:0] PEND_SRC = ~(NUM_SRC'(1) << SRC_RF);

   trig_state_e          state_q, state_d;
   logic [NUM_SRC-1:0]   src_lvl, evt;
   logic [NUM_SRC-1:0]   pend_q, pend_all;
   logic [HO_W-1:0]      ho_cnt_q;
   logic                 idle_ok, rf_acc, rf_drop, rf_fire, fire, ho_err_set;

   always_comb begin
      src_lvl           = '0;
      src_lvl[SRC_RF]   = rf_trig_i;
      src_lvl[SRC_PPS]  = pps_trig_i;
      src_lvl[SRC_EXT]  = ext_trig_i;
      src_lvl[SRC_SOFT] = soft_trig_i;
   end

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_edge
      anita3_trig_edge u_edge (
         .clk250_i (clk250_i),
         .rst_n_i  (rst_n_i),
         .level    (src_lvl[g]),
         .enable   (trig_mask_i[g]),
         .rise     (evt[g])
      );
   end

   assign idle_ok  = (state_q == ST_IDLE) & ~busy_i & ~holdoff_i;
   assign rf_acc   = evt[SRC_RF] & idle_ok;
   assign rf_drop  = evt[SRC_RF] & ~idle_ok;
   assign pend_all = pend_q | (evt & PEND_SRC);

`ifdef ANITA3_TRIG_PRESCALE_EN
   // Counts accepted RF events; restarts whenever the divisor is rewritten.
   logic [7:0] ps_cnt_q, ps_last_q;
   logic       ps_hit;

   assign ps_hit  = (ps_cnt_q == rf_prescale_i);
   assign rf_fire = rf_acc & ps_hit;

   always_ff @(posedge clk250_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ps_cnt_q  <= '0;
         ps_last_q <= '0;
      end else begin
         ps_last_q <= rf_prescale_i;
         if (rf_prescale_i != ps_last_q) ps_cnt_q <= '0;
         else if (rf_acc)                ps_cnt_q <= ps_hit ? 8'd0 : ps_cnt_q + 8'd1;
      end
   end
`else
   assign rf_fire = rf_acc;
`endif

   assign fire   = idle_ok & (rf_fire | (|pend_all));
   assign trig_o = (state_q == ST_FIRE);

   always_comb begin
      state_d    = state_q;
      ho_err_set = 1'b0;
      case (state_q)
         ST_IDLE:     if (fire) state_d = ST_FIRE;
         ST_FIRE:     state_d = ST_WAIT_HO;
         ST_WAIT_HO: begin
            if (holdoff_i) begin
               state_d = ST_WAIT_CLR;
            end else if (ho_cnt_q == '0) begin
               state_d    = ST_IDLE;
               ho_err_set = 1'b1;
            end
         end
         ST_WAIT_CLR: if (!holdoff_i) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk250_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk250_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pend_q        <= '0;
         trig_type_o   <= '0;
         event_count_o <= '0;
         rf_dropped_o  <= '0;
         ho_error_o    <= 1'b0;
         ho_cnt_q      <= '0;
      end else begin
         if (fire && state_q == ST_IDLE) begin
            pend_q      <= '0;
            trig_type_o <= pend_all | (NUM_SRC'(rf_fire) << SRC_RF);
         end else begin
            pend_q      <= pend_all & trig_mask_i;
         end
         if (state_q == ST_FIRE) begin
            event_count_o <= event_count_o + EVCNT_WIDTH'(1);
            ho_cnt_q      <= HO_LOAD;
         end else if (state_q == ST_WAIT_HO && ho_cnt_q != '0) begin
            ho_cnt_q      <= ho_cnt_q - HO_W'(1);
         end
         if (rf_drop && rf_dropped_o != '1) rf_dropped_o <= rf_dropped_o + DROP_WIDTH'(1);
         if (ho_err_set) ho_error_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_anita3_trigger_gate.sv
// Directed self-checking bench for anita3_trigger_gate with a simple holdoff
// block model (asserts one cycle after trig_o, for 34 cycles).
`timescale 1ns/1ps
module tb_anita3_trigger_gate;

   logic        clk250_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        rf_trig_i = 1'b0, pps_trig_i = 1'b0, ext_trig_i = 1'b0, soft_trig_i = 1'b0;
   logic [3:0]  trig_mask_i = 4'hF;
   logic        busy_i = 1'b0, holdoff_i = 1'b0;
   logic        trig_o;
   logic [3:0]  trig_type_o;
   logic [31:0] event_count_o;
   logic [15:0] rf_dropped_o;
   logic        ho_error_o;
`ifdef ANITA3_TRIG_PRESCALE_EN
   logic [7:0]  rf_prescale_i = 8'd0;
`endif

   int checks = 0;
   int errors = 0;
   int n_trig = 0;
   int ho_left = 0;
   bit ho_arm = 0;
   bit ho_auto = 1;
   int exp_ev = 0;
   int exp_drop = 0;

   anita3_trigger_gate dut (
      .clk250_i      (clk250_i),
      .rst_n_i       (rst_n_i),
      .rf_trig_i     (rf_trig_i),
      .pps_trig_i    (pps_trig_i),
      .ext_trig_i    (ext_trig_i),
      .soft_trig_i   (soft_trig_i),
`ifdef ANITA3_TRIG_PRESCALE_EN
      .rf_prescale_i (rf_prescale_i),
`endif
      .trig_mask_i   (trig_mask_i),
      .busy_i        (busy_i),
      .holdoff_i     (holdoff_i),
      .trig_o        (trig_o),
      .trig_type_o   (trig_type_o),
      .event_count_o (event_count_o),
      .rf_dropped_o  (rf_dropped_o),
      .ho_error_o    (ho_error_o)
   );

   always #2 clk250_i = ~clk250_i;

   // Advance one cycle; sample 1 ns after the edge and run the holdoff model.
   task automatic tick();
      @(posedge clk250_i);
      #1;
      if (trig_o) n_trig++;
      if (ho_auto) begin
         if (ho_left > 0) begin
            ho_left--;
            if (ho_left == 0) holdoff_i = 1'b0;
         end
         if (ho_arm) begin
            holdoff_i = 1'b1;
            ho_left   = 34;
            ho_arm    = 0;
         end
         if (trig_o) ho_arm = 1;
      end
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({trig_o, trig_type_o, event_count_o, rf_dropped_o, ho_error_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got trig=%0b type=%0h ev=%0d drop=%0d err=%0b exp all 0",
                  trig_o, trig_type_o, event_count_o, rf_dropped_o, ho_error_o);
      end
      settle(2);
      rst_n_i = 1'b1;
      settle(2);
   endtask

   task automatic test_rf_single();
      int base;
      rf_trig_i = 1'b1;
      tick();
      rf_trig_i = 1'b0;
      exp_ev++;
      checks++;
      if (trig_o !== 1'b1 || trig_type_o !== 4'b0001) begin
         errors++;
         $display("FAIL rf_single_fire got trig=%0b type=%b exp trig=1 type=0001", trig_o, trig_type_o);
      end
      base = n_trig;
      tick();
      checks++;
      if (trig_o !== 1'b0 || event_count_o !== 32'(exp_ev)) begin
         errors++;
         $display("FAIL rf_single_after got trig=%0b ev=%0d exp trig=0 ev=%0d", trig_o, event_count_o, exp_ev);
      end
      settle(40);
      checks++;
      if (n_trig - base !== 0) begin
         errors++;
         $display("FAIL rf_single_extra got %0d extra triggers exp 0", n_trig - base);
      end
   endtask

   task automatic test_rf_drop();
      int base;
      base = n_trig;
      rf_trig_i = 1'b1;
      tick();
      rf_trig_i = 1'b0;
      exp_ev++;
      for (int j = 1; j <= 45; j++) begin
         rf_trig_i = (j == 10);
         tick();
      end
      rf_trig_i = 1'b0;
      exp_drop++;
      checks++;
      if (n_trig - base !== 1) begin
         errors++;
         $display("FAIL rf_drop_triggers got %0d exp 1", n_trig - base);
      end
      checks++;
      if (rf_dropped_o !== 16'(exp_drop) || event_count_o !== 32'(exp_ev)) begin
         errors++;
         $display("FAIL rf_drop_counts got drop=%0d ev=%0d exp drop=%0d ev=%0d",
                  rf_dropped_o, event_count_o, exp_drop, exp_ev);
      end
   endtask

   task automatic test_soft_pending();
      int first = 0;
      logic [3:0] typ = '0;
      rf_trig_i = 1'b1;
      tick();
      rf_trig_i = 1'b0;
      for (int j = 1; j <= 60; j++) begin
         soft_trig_i = (j == 10);
         tick();
         if (trig_o && first == 0) begin
            first = j;
            typ   = trig_type_o;
         end
      end
      soft_trig_i = 1'b0;
      exp_ev += 2;
      checks++;
      if (first !== 37) begin
         errors++;
         $display("FAIL soft_pending_latency got cycle %0d exp 37", first);
      end
      checks++;
      if (typ !== 4'b1000) begin
         errors++;
         $display("FAIL soft_pending_type got %b exp 1000", typ);
      end
      settle(20);
      checks++;
      if (event_count_o !== 32'(exp_ev)) begin
         errors++;
         $display("FAIL soft_pending_count got %0d exp %0d", event_count_o, exp_ev);
      end
   endtask

   task automatic test_simultaneous();
      rf_trig_i  = 1'b1;
      pps_trig_i = 1'b1;
      tick();
      rf_trig_i  = 1'b0;
      pps_trig_i = 1'b0;
      exp_ev++;
      checks++;
      if (trig_o !== 1'b1 || trig_type_o !== 4'b0011) begin
         errors++;
         $display("FAIL simul_fire got trig=%0b type=%b exp trig=1 type=0011", trig_o, trig_type_o);
      end
      tick();
      checks++;
      if (trig_o !== 1'b0 || event_count_o !== 32'(exp_ev)) begin
         errors++;
         $display("FAIL simul_count got trig=%0b ev=%0d exp trig=0 ev=%0d", trig_o, event_count_o, exp_ev);
      end
      settle(40);
   endtask

   task automatic test_busy();
      busy_i     = 1'b1;
      rf_trig_i  = 1'b1;
      ext_trig_i = 1'b1;
      tick();
      rf_trig_i  = 1'b0;
      ext_trig_i = 1'b0;
      exp_drop++;
      tick();
      checks++;
      if (trig_o !== 1'b0 || rf_dropped_o !== 16'(exp_drop)) begin
         errors++;
         $display("FAIL busy_block got trig=%0b drop=%0d exp trig=0 drop=%0d", trig_o, rf_dropped_o, exp_drop);
      end
      busy_i = 1'b0;
      tick();
      exp_ev++;
      checks++;
      if (trig_o !== 1'b1 || trig_type_o !== 4'b0100) begin
         errors++;
         $display("FAIL busy_release got trig=%0b type=%b exp trig=1 type=0100", trig_o, trig_type_o);
      end
      settle(40);
   endtask

   task automatic test_mask_clear();
      int base;
      rf_trig_i = 1'b1;
      tick();
      rf_trig_i = 1'b0;
      exp_ev++;
      base = n_trig;
      for (int j = 1; j <= 60; j++) begin
         ext_trig_i = (j == 5);
         if (j == 10) trig_mask_i = 4'b1011;
         tick();
      end
      ext_trig_i  = 1'b0;
      trig_mask_i = 4'b1110;
      rf_trig_i   = 1'b1;
      tick();
      rf_trig_i   = 1'b0;
      settle(3);
      trig_mask_i = 4'hF;
      checks++;
      if (n_trig - base !== 0) begin
         errors++;
         $display("FAIL mask_clear_triggers got %0d exp 0", n_trig - base);
      end
      checks++;
      if (rf_dropped_o !== 16'(exp_drop) || event_count_o !== 32'(exp_ev)) begin
         errors++;
         $display("FAIL mask_counts got drop=%0d ev=%0d exp drop=%0d ev=%0d",
                  rf_dropped_o, event_count_o, exp_drop, exp_ev);
      end
   endtask

   task automatic test_ho_timeout();
      ho_auto   = 0;
      holdoff_i = 1'b0;
      rf_trig_i = 1'b1;
      tick();
      rf_trig_i = 1'b0;
      exp_ev++;
      settle(3);
      checks++;
      if (ho_error_o !== 1'b0) begin
         errors++;
         $display("FAIL ho_error_early got %0b exp 0", ho_error_o);
      end
      tick();
      checks++;
      if (ho_error_o !== 1'b1) begin
         errors++;
         $display("FAIL ho_error_set got %0b exp 1", ho_error_o);
      end
      rf_trig_i = 1'b1;
      tick();
      rf_trig_i = 1'b0;
      exp_ev++;
      checks++;
      if (trig_o !== 1'b1 || trig_type_o !== 4'b0001 || ho_error_o !== 1'b1) begin
         errors++;
         $display("FAIL ho_recover got trig=%0b type=%b err=%0b exp trig=1 type=0001 err=1",
                  trig_o, trig_type_o, ho_error_o);
      end
   endtask

   task automatic test_reset_midop();
      holdoff_i = 1'b1;
      settle(2);
      checks++;
      if (event_count_o !== 32'(exp_ev)) begin
         errors++;
         $display("FAIL pre_reset_count got %0d exp %0d", event_count_o, exp_ev);
      end
      rst_n_i = 1'b0;
      #1;
      checks++;
      if ({trig_o, trig_type_o, event_count_o, rf_dropped_o, ho_error_o} !== '0) begin
         errors++;
         $display("FAIL async_reset got trig=%0b type=%0h ev=%0d drop=%0d err=%0b exp all 0",
                  trig_o, trig_type_o, event_count_o, rf_dropped_o, ho_error_o);
      end
      holdoff_i = 1'b0;
      tick();
      rst_n_i = 1'b1;
      tick();
      rf_trig_i = 1'b1;
      tick();
      rf_trig_i = 1'b0;
      checks++;
      if (trig_o !== 1'b1 || ho_error_o !== 1'b0 || event_count_o !== 32'd0) begin
         errors++;
         $display("FAIL post_reset_fire got trig=%0b err=%0b ev=%0d exp trig=1 err=0 ev=0",
                  trig_o, ho_error_o, event_count_o);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_rf_single();
      test_rf_drop();
      test_soft_pending();
      test_simultaneous();
      test_busy();
      test_mask_clear();
      test_ho_timeout();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached exp completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/anita3_trigger_gate.md
Name: anita3_trigger_gate

Overview:
- Trigger arbitration stage directly upstream of the trigger holdoff block.
- Merges four trigger sources (RF L3, PPS, external, software) into one single-cycle trigger pulse that drives the holdoff block's trigger input.
- Consumes the holdoff block's holdoff output to gate further triggers.
- Tags each trigger with a source bitmap and an event number.

Parameters:
EVCNT_WIDTH, 32, width of event counter (wraps)
DROP_WIDTH, 16, width of RF-dropped counter (saturates)
HO_TIMEOUT, 3, max cycles to wait for holdoff_i assertion after a trigger

Ports:
clk250_i  in  1  250 MHz system clock; all inputs synchronous to it
rst_n_i  in  1  asynchronous active-low reset
rf_trig_i  in  1  RF L3 trigger (level; rising edge = event)
pps_trig_i  in  1  PPS trigger (rising edge = event)
ext_trig_i  in  1  external trigger (rising edge = event)
soft_trig_i  in  1  software trigger (rising edge = event)
trig_mask_i  in  4  source enable, bit0 rf, bit1 pps, bit2 ext, bit3 soft; 1 = enabled
busy_i  in  1  readout buffers full; blocks firing
holdoff_i  in  1  holdoff from downstream holdoff block
trig_o  out  1  one-cycle trigger pulse to holdoff block
trig_type_o  out  4  source bitmap of the last trigger (same bit order as mask)
event_count_o  out  EVCNT_WIDTH  number of triggers issued
rf_dropped_o  out  DROP_WIDTH  RF events rejected while not IDLE or blocked
ho_error_o  out  1  sticky: holdoff_i failed to assert within HO_TIMEOUT

Behaviour:
- Reset: all outputs 0, FSM to IDLE, pending bits 0, edge registers 0. Reset mid-operation aborts any state immediately, with no trigger emitted.
- Edge detect: per source, event = input & ~prev & mask bit. prev is registered every cycle regardless of the mask.
- Pending: pps/ext/soft events set a pending bit in any state. A repeat event on a set bit merges with it (no count). Clearing a mask bit clears that pending bit on the next edge.
- RF: never pending. It is accepted only in IDLE with busy_i=0 and holdoff_i=0. Otherwise it is dropped and rf_dropped_o increments, saturating at all-ones.
- FSM states: IDLE, FIRE, WAIT_HO, WAIT_CLR.
- IDLE -> FIRE: (rf event | any pending) & ~busy_i & ~holdoff_i.
  - On that edge, trig_type_o <= {pending | new events, rf event}.
  - The serviced pending bits clear.
  - Events arriving in the same cycle are included.
- FIRE: trig_o = 1 for exactly this cycle. event_count_o increments on exit (wraps). Next state is WAIT_HO. Events arriving during FIRE become pending.
- WAIT_HO: on holdoff_i=1 go to WAIT_CLR. After HO_TIMEOUT cycles without it, set ho_error_o and go to IDLE.
- WAIT_CLR: on holdoff_i=0 go to IDLE.
- Latency: a source edge visible at clock edge N gives trig_o high in the cycle following edge N (1 cycle). trig_o is registered (state==FIRE).
- Minimum spacing between triggers = 1 + holdoff duration + 1 cycles.
- Simultaneous sources: all are merged into one trigger, with multiple bits set in trig_type_o.
- busy_i rising while in WAIT_*: no effect until the IDLE decision.

Optional Feature:
- Macro: ANITA3_TRIG_PRESCALE_EN.
- When defined:
  - Adds input rf_prescale_i[7:0].
  - Only every (rf_prescale_i+1)-th accepted RF event fires.
  - Prescaled-away RF events are not counted as dropped.
  - The prescale counter resets on reset and whenever rf_prescale_i changes.
- When undefined: every accepted RF event fires, and the port is absent.

Decomposition:
- Package anita3_trig_pkg holds:
  - FSM state encoding.
  - Source bit indices (SRC_RF=0, SRC_PPS=1, SRC_EXT=2, SRC_SOFT=3).
  - NUM_SRC=4.
  - Default widths.
- Sub-module anita3_trig_edge: per-source prev register and rising-edge/mask qualification, instantiated 4x.

Test Plan:
- RF pulse at cycle 10, mask=4'hF, holdoff model asserts 1 cycle after trig_o for 34 cycles -> trig_o high at cycle 11 only, trig_type_o=4'b0001, event_count_o=1.
- RF pulses at 10 and 20 (during holdoff) -> one trigger; rf_dropped_o=1; event_count_o=1.
- soft_trig_i pulse at cycle 20 during holdoff -> pending. trig_o fires 1 cycle after holdoff_i falls (IDLE), trig_type_o=4'b1000.
- RF and PPS edges in the same cycle -> single trig_o, trig_type_o=4'b0011, event_count_o increments by 1.
- busy_i=1 with RF edge and ext edge -> no trig_o, rf_dropped_o=1. busy_i drops -> trigger with trig_type_o=4'b0100.
- holdoff_i held 0 after trig_o -> ho_error_o=1 after 3 cycles, FSM back to IDLE. Next RF edge fires normally. Assert rst_n_i=0 in WAIT_CLR -> all outputs 0 asynchronously.
